// File: rtl/mult_unit_pkg.sv
// Shared constants for the iterative HI/LO multiplier.
//   mult_state_e : FSM state encoding (IDLE=0, BUSY=1, FIX=2)
//   MULT_WIDTH   : architectural operand width
//   MULT_CYCLES  : cycles from an accepted start to the HI/LO update edge,
//                  exported so the hazard unit and benches agree on latency
package mult_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2
   } mult_state_e;

   localparam int MULT_WIDTH          = 32;
   localparam int MULT_BITS_PER_CYCLE = 1;
   localparam int MULT_CYCLES         = MULT_WIDTH / MULT_BITS_PER_CYCLE + 1;

   // Latency for a non-default iteration radix.
   function automatic int mult_cycles(input int width, input int bits_per_cycle);
      return width / bits_per_cycle + 1;
   endfunction

endpackage

// File: rtl/mult_step.sv
// One add-and-shift iteration of an unsigned radix-2^BITS_PER_CYCLE multiplier.
//   mcand     : multiplicand magnitude
//   acc       : running upper partial product (WIDTH+BITS_PER_CYCLE bits)
//   mplr      : remaining multiplier bits; low bits fill with retired product bits
//   acc_next  : acc after adding mcand*digit and shifting right
//   mplr_next : mplr shifted right with the product's low bits shifted in
module mult_step #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [WIDTH-1:0]                acc_dummy_unused_never,
   input  logic [WIDTH-1:0]                mcand,
   input  logic [WIDTH+BITS_PER_CYCLE-1:0] acc,
   input  logic [WIDTH-1:0]                mplr,
   output logic [WIDTH+BITS_PER_CYCLE-1:0] acc_next,
   output logic [WIDTH-1:0]                mplr_next
);

   localparam int AW = WIDTH + BITS_PER_CYCLE;

   logic [AW-1:0] partial;
   logic [AW-1:0] sum;
   logic          unused_ok;

   // acc enters below 2^WIDTH, so acc + mcand*digit always fits in AW bits.
   always_comb begin
      partial   = {{BITS_PER_CYCLE{1'b0}}, mcand} * {{WIDTH{1'b0}}, mplr[BITS_PER_CYCLE-1:0]};
      sum       = acc + partial;
      acc_next  = {{BITS_PER_CYCLE{1'b0}}, sum[AW-1:BITS_PER_CYCLE]};
      mplr_next = {sum[BITS_PER_CYCLE-1:0], mplr[WIDTH-1:BITS_PER_CYCLE]};
      unused_ok = ^acc_dummy_unused_never;
   end

endmodule

// File: rtl/mult_unit.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier owning the HI/LO registers.
// Responds to the hazard unit's multiply stall handshake: pve drops on the
// edge that accepts multstartE and returns high on the edge HI/LO are written.
//   clk, reset          : clock, asynchronous active-high reset
//   multstartE, signedE : start request (IDLE only), 1 = signed mult
//   srcaE, srcbE        : multiplicand / multiplier; srcaE also feeds mthi/mtlo
//   hiwriteE, lowriteE  : mthi / mtlo (IDLE only)
//   pve, busy           : product valid / operation in progress (registered)
//   hi, lo              : architectural HI / LO
//
// state | meaning
// IDLE  | no operation; accepts start and mthi/mtlo
// BUSY  | one add-and-shift iteration per cycle on the magnitudes
// FIX   | apply result sign, write HI/LO, raise pve
module mult_unit
   import mult_unit_pkg::*;
#(
   parameter int WIDTH          = MULT_WIDTH,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             multstartE,
   input  logic             signedE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             hiwriteE,
   input  logic             lowriteE,
   output logic             pve,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int AW    = WIDTH + BITS_PER_CYCLE;
   localparam int STEPS = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_radix
      $error("mult_unit: BITS_PER_CYCLE must divide WIDTH");
   end

   mult_state_e      state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             pve_q, pve_d;
   logic             busy_q, busy_d;

   logic [AW-1:0]      acc_step;
   logic [WIDTH-1:0]   mplr_step;
   logic [2*WIDTH-1:0] prod_mag;
   logic [2*WIDTH-1:0] prod_fix;

   mult_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .acc_dummy_unused_never ('0),
      .mcand                  (mcand_q),
      .acc                    (acc_q),
      .mplr                   (mplr_q),
      .acc_next               (acc_step),
      .mplr_next              (mplr_step)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         count_q <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         pve_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pve_q   <= pve_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      acc_d   = acc_q;
      count_d = count_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      pve_d   = pve_q;
      busy_d  = busy_q;

      // After the last shift acc is below 2^WIDTH, so only its low half matters.
      prod_mag = {acc_q[WIDTH-1:0], mplr_q};
      prod_fix = neg_q ? (~prod_mag + 1'b1) : prod_mag;

      unique case (state_q)
         IDLE: begin
            if (hiwriteE) hi_d = srcaE;
            if (lowriteE) lo_d = srcaE;
            if (multstartE) begin
               // Negating the most negative value yields 2^(WIDTH-1), which is
               // the right magnitude because everything downstream is unsigned.
               mcand_d = (signedE && srcaE[WIDTH-1]) ? (~srcaE + 1'b1) : srcaE;
               mplr_d  = (signedE && srcbE[WIDTH-1]) ? (~srcbE + 1'b1) : srcbE;
               neg_d   = signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
               acc_d   = '0;
               count_d = '0;
               pve_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            acc_d   = acc_step;
            mplr_d  = mplr_step;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_STEP) state_d = FIX;
         end
         FIX: begin
            hi_d    = prod_fix[2*WIDTH-1:WIDTH];
            lo_d    = prod_fix[WIDTH-1:0];
            pve_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign pve  = pve_q;
   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;
   import mult_unit_pkg::*;

   localparam int N1 = MULT_CYCLES;            // 33
   localparam int N4 = mult_cycles(32, 4);     // 9

   logic        clk = 1'b0;
   logic        reset;
   logic        multstartE, signedE, hiwriteE, lowriteE;
   logic [31:0] srcaE, srcbE;
   logic        pve, busy, pve4, busy4;
   logic [31:0] hi, lo, hi4, lo4;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   always #5 clk = ~clk;

   mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .reset(reset), .multstartE(multstartE), .signedE(signedE),
      .srcaE(srcaE), .srcbE(srcbE), .hiwriteE(hiwriteE), .lowriteE(lowriteE),
      .pve(pve), .busy(busy), .hi(hi), .lo(lo)
   );

   mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .reset(reset), .multstartE(multstartE), .signedE(signedE),
      .srcaE(srcaE), .srcbE(srcbE), .hiwriteE(hiwriteE), .lowriteE(lowriteE),
      .pve(pve4), .busy(busy4), .hi(hi4), .lo(lo4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called #1 after a posedge; the start is sampled at the next edge (edge 0).
   task automatic run_mult(input string tag, input logic sg,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el,
                           input bit chk4, input bit mtlo_start, input bit disturb);
      signedE    = sg;
      srcaE      = a;
      srcbE      = b;
      multstartE = 1'b1;
      lowriteE   = mtlo_start;
      @(posedge clk); #1;
      multstartE = 1'b0;
      lowriteE   = 1'b0;
      chk({tag, " pve_e1"}, {63'd0, pve}, 64'd0);
      chk({tag, " busy_e1"}, {63'd0, busy}, 64'd1);
      if (mtlo_start) chk({tag, " mtlo_with_start"}, {32'd0, lo}, {32'd0, a});
      for (int e = 1; e <= N1; e++) begin
         @(posedge clk); #1;
         if (disturb && e == 4) begin
            srcaE      = 32'h0000DEAD;
            lowriteE   = 1'b1;
            multstartE = 1'b1;
         end
         if (disturb && e == 5) begin
            lowriteE   = 1'b0;
            multstartE = 1'b0;
            srcaE      = a;
         end
         if (disturb && e == 6) begin
            chk({tag, " mtlo_busy_ignored"}, {32'd0, lo}, 64'd0);
            chk({tag, " hi_held_busy"}, {32'd0, hi}, 64'h1234);
         end
         if (e == N1 - 1) begin
            chk({tag, " pve_last_busy"}, {63'd0, pve}, 64'd0);
            chk({tag, " busy_last"}, {63'd0, busy}, 64'd1);
         end
         if (e == N1) begin
            chk({tag, " hilo"}, {hi, lo}, {eh, el});
            chk({tag, " pve_done"}, {63'd0, pve}, 64'd1);
            chk({tag, " busy_done"}, {63'd0, busy}, 64'd0);
         end
         if (chk4 && e == N4 - 1) chk({tag, " r4_pve_busy"}, {63'd0, pve4}, 64'd0);
         if (chk4 && e == N4) begin
            chk({tag, " r4_hilo"}, {hi4, lo4}, {eh, el});
            chk({tag, " r4_pve"}, {63'd0, pve4}, 64'd1);
         end
      end
      @(posedge clk); #1;
      chk({tag, " hold"}, {hi, lo}, {eh, el});
      chk({tag, " idle_after"}, {62'd0, pve, busy}, 64'd2);
   endtask

   initial begin
      reset      = 1'b1;
      multstartE = 1'b0;
      signedE    = 1'b0;
      hiwriteE   = 1'b0;
      lowriteE   = 1'b0;
      srcaE      = '0;
      srcbE      = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {hi, lo}, 64'd0);
      chk("reset_pve_busy", {62'd0, pve, busy}, 64'd2);
      reset = 1'b0;

      run_mult("multu_3x5",  1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F, 1, 0, 0);
      run_mult("mult_m2x3",  1'b1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1, 0, 0);
      run_mult("multu_max",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1, 0, 0);
      run_mult("mult_min",   1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1, 0, 0);
      run_mult("mult_mix",   1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1, 0, 0);
      run_mult("multu_mtlo", 1'b0, 32'd6,        32'd7,        32'h00000000, 32'h0000002A, 0, 1, 0);

      // Abort mid-operation; hi/lo were nonzero before the reset.
      run_mult("mult_prev",  1'b1, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFB, 0, 0, 0);
      signedE    = 1'b0;
      srcaE      = 32'd7;
      srcbE      = 32'd9;
      multstartE = 1'b1;
      @(posedge clk); #1;
      multstartE = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("async_reset_hilo", {hi, lo}, 64'd0);
      chk("async_reset_pve_busy", {62'd0, pve, busy}, 64'd2);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_idle", {62'd0, pve, busy}, 64'd2);
      run_mult("multu_7x9",  1'b0, 32'd7,        32'd9,        32'h00000000, 32'h0000003F, 1, 0, 0);

      // Reset to clear lo, mthi, then a start disturbed by mtlo and a second start.
      reset = 1'b1;
      #1;
      reset = 1'b0;
      hiwriteE = 1'b1;
      srcaE    = 32'h00001234;
      @(posedge clk); #1;
      hiwriteE = 1'b0;
      chk("mthi_idle", {hi, lo}, {32'h00001234, 32'h0});
      run_mult("mult_2x2_dist", 1'b0, 32'd2, 32'd2, 32'h00000000, 32'h00000004, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
